// File: rtl/rsa_modexp_decrypt_if.sv
// Host-side handshake bundle for the RSA decrypt exponentiator.
// The host (master) issues start with the operands. The exponentiator (slave)
// answers with busy, done, the plaintext word and the error flag.
interface rsa_modexp_decrypt_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] n_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] m_out;
  logic             error;

  modport master (
    output start, c_in, d_in, n_in,
    input  busy, done, m_out, error
  );

  modport slave (
    input  start, c_in, d_in, n_in,
    output busy, done, m_out, error
  );
endinterface

// File: rtl/rsa_modexp_decrypt.sv
// RSA private-key exponentiator: M = C^d mod n.
// The exponent is scanned left to right with square-and-multiply. Each modular
// product is an interleaved shift-add reduction that takes one multiplier bit
// per cycle. Latency therefore depends only on popcount(d), never on the other
// operand values.
module rsa_modexp_decrypt #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_modexp_decrypt_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP_BIT = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    PRERED = 3'd2,
    SQUARE = 3'd3,
    MULT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched operands
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_n;

  // Exponentiation state
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_base;
  logic [IW-1:0]    r_i;

  // Modular-multiply engine: r = a*b mod n, one bit of a per cycle
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [IW-1:0]    r_j;

  // Result registers that hold between operations
  logic [WIDTH-1:0] r_m;
  logic             r_err;

  logic [WIDTH-1:0] w_r_next;
  logic             w_mm_last;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_m_out;

  // One shift-add reduction step. r < n and b < n give t < 3n, so two
  // conditional subtractions always bring the result back below n.
  // t needs two bits of headroom above WIDTH.
  function automatic logic [WIDTH-1:0] mm_step(
    input logic [WIDTH-1:0] r,
    input logic             abit,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nn;
    nn = {2'b00, n};
    t  = {1'b0, r, 1'b0} + {2'b00, (abit ? b : {WIDTH{1'b0}})};
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  assign w_r_next  = mm_step(r_r, r_a[r_j], r_b, r_n);
  assign w_mm_last = (r_j == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: each multiply phase ends when its bit pointer reaches 0
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (bus.start) w_next_state = CHECK;
      CHECK:  w_next_state = (r_n < WIDTH'(2)) ? FINISH : PRERED;
      PRERED: if (w_mm_last) w_next_state = SQUARE;
      SQUARE: begin
        if (w_mm_last) begin
          if (r_d[r_i])         w_next_state = MULT;
          else if (r_i == '0)   w_next_state = FINISH;
          else                  w_next_state = SQUARE;
        end
      end
      MULT:   if (w_mm_last) w_next_state = (r_i == '0) ? FINISH : SQUARE;
      FINISH: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: busy spans CHECK..MULT. The result appears in FINISH and is held afterwards.
  always_comb begin
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_m_out = r_m;
    case (r_state)
      CHECK, PRERED, SQUARE, MULT: w_busy = 1'b1;
      FINISH: begin
        w_done  = 1'b1;
        w_m_out = r_acc;
      end
      default: ;
    endcase
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.m_out = w_m_out;
  assign bus.error = r_err;

  // Datapath: operand capture, multiply steps and phase hand-over.
  // Each phase loads the engine operands for the following phase, so the
  // engine never idles between products.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c    <= '0;
      r_d    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_base <= '0;
      r_i    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_r    <= '0;
      r_j    <= '0;
      r_m    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_c   <= bus.c_in;
            r_d   <= bus.d_in;
            r_n   <= bus.n_in;
            r_m   <= '0;
            r_err <= 1'b0;
          end
        end
        CHECK: begin
          if (r_n < WIDTH'(2)) begin
            r_err <= 1'b1;
            r_acc <= '0;
          end else begin
            r_acc <= WIDTH'(1);
            r_i   <= TOP_BIT;
            // Pre-reduction: base = C * 1 mod n, which also handles C >= n
            r_a   <= r_c;
            r_b   <= WIDTH'(1);
            r_r   <= '0;
            r_j   <= TOP_BIT;
          end
        end
        PRERED: begin
          r_r <= w_r_next;
          r_j <= r_j - 1'b1;
          if (w_mm_last) begin
            r_base <= w_r_next;
            r_a    <= r_acc;
            r_b    <= r_acc;
            r_r    <= '0;
            r_j    <= TOP_BIT;
          end
        end
        SQUARE: begin
          r_r <= w_r_next;
          r_j <= r_j - 1'b1;
          if (w_mm_last) begin
            r_acc <= w_r_next;
            r_a   <= w_r_next;
            r_r   <= '0;
            r_j   <= TOP_BIT;
            if (r_d[r_i]) begin
              r_b <= r_base;
            end else begin
              r_b <= w_r_next;
              r_i <= r_i - 1'b1;
            end
          end
        end
        MULT: begin
          r_r <= w_r_next;
          r_j <= r_j - 1'b1;
          if (w_mm_last) begin
            r_acc <= w_r_next;
            r_a   <= w_r_next;
            r_b   <= w_r_next;
            r_r   <= '0;
            r_j   <= TOP_BIT;
            r_i   <= r_i - 1'b1;
          end
        end
        FINISH: r_m <= r_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Scoreboard bench for rsa_modexp_decrypt: a driver pushes expected results
// computed by a plain-arithmetic modexp model, and a monitor pops and compares
// them whenever done is seen.
module tb_rsa_modexp_decrypt;
  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] m;
    logic             err;
    int               lat;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic busy_bad = 1'b0;
  exp_t sb[$];

  rsa_modexp_decrypt_if #(.WIDTH(WIDTH)) bus ();

  rsa_modexp_decrypt #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Reference: right-to-left binary exponentiation on wide integers
  function automatic longint unsigned ref_modexp(longint unsigned c, logic [WIDTH-1:0] d,
                                                 longint unsigned n);
    longint unsigned b, r;
    if (n < 2) return 0;
    b = c % n;
    r = 1;
    for (int k = 0; k < WIDTH; k++) begin
      if (d[k]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic int ref_lat(logic [WIDTH-1:0] d, logic [WIDTH-1:0] n);
    if (n < 2) return 2;
    return 18 + 16 * (WIDTH + $countones(d));
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_out", bus.m_out, e.m);
          check("error", bus.error, e.err);
          check("latency", cyc + 1 - e.acc_cyc, e.lat);
          check("busy_at_done", bus.busy, 0);
          check("busy_during_op", busy_bad, 0);
          busy_bad = 1'b0;
        end
      end else if (sb.size() != 0 && !bus.busy) begin
        busy_bad = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      check("idle_timeout", k, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
    end
  endtask

  task automatic run_op(logic [WIDTH-1:0] c, logic [WIDTH-1:0] d, logic [WIDTH-1:0] n);
    exp_t e;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.c_in  = c;
    bus.d_in  = d;
    bus.n_in  = n;
    @(posedge clk);
    #1;
    e.m       = WIDTH'(ref_modexp(c, d, n));
    e.err     = (n < 2);
    e.lat     = ref_lat(d, n);
    e.acc_cyc = cyc;
    busy_bad  = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.c_in  = '0;
    bus.d_in  = '0;
    bus.n_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_m_out", bus.m_out, 0);
    check("rst_error", bus.error, 0);
    reset = 1'b0;

    // Directed cases
    run_op(16'd2790, 16'd2753, 16'd3233);
    run_op(16'd5000, 16'd1, 16'd3233);
    run_op(16'd65534, 16'd2, 16'd65535);
    run_op(16'd1234, 16'd0, 16'd3233);
    run_op(16'd77, 16'd5, 16'd1);
    run_op(16'd77, 16'd5, 16'd0);

    // Start while busy: must be ignored
    run_op(16'd2790, 16'd2753, 16'd3233);
    repeat (50) @(negedge clk);
    bus.start = 1'b1;
    bus.c_in  = 16'd11;
    bus.d_in  = 16'd3;
    bus.n_in  = 16'd97;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("after_busy_start_m_out", bus.m_out, 65);

    // Reset mid-operation
    run_op(16'd2790, 16'd2753, 16'd3233);
    repeat (98) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_m_out", bus.m_out, 0);
    check("midrst_error", bus.error, 0);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    run_op(16'd2790, 16'd2753, 16'd3233);

    // Randomized cases
    for (int t = 0; t < 16; t++) begin
      logic [WIDTH-1:0] rc, rd, rn;
      rc = WIDTH'($urandom);
      rd = WIDTH'($urandom);
      rn = (t % 8 == 7) ? WIDTH'($urandom_range(0, 1)) : WIDTH'($urandom_range(2, 65535));
      run_op(rc, rd, rn);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
